// File: rtl/wfg_drive_pwm_if.sv
// Bus bundle for wfg_drive_pwm: Wishbone slave port plus the sample AXI-Stream.
// slave = the PWM driver side, master = the bus/stream source side.
interface wfg_drive_pwm_if #(
  parameter int BUSW = 32
);
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
  logic              wbs_we_i;
  logic [BUSW/8-1:0] wbs_sel_i;
  logic [BUSW-1:0]   wbs_dat_i;
  logic [BUSW-1:0]   wbs_adr_i;
  logic              wbs_ack_o;
  logic [BUSW-1:0]   wbs_dat_o;
  logic              wfg_axis_tready_o;
  logic              wfg_axis_tvalid_i;
  logic [31:0]       wfg_axis_tdata_i;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    output wbs_ack_o, wbs_dat_o,
    output wfg_axis_tready_o,
    input  wfg_axis_tvalid_i, wfg_axis_tdata_i
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
    input  wbs_ack_o, wbs_dat_o,
    input  wfg_axis_tready_o,
    output wfg_axis_tvalid_i, wfg_axis_tdata_i
  );
endinterface

// File: rtl/wfg_drive_pwm.sv
// wfg_drive_pwm: turns each stream sample into one PWM period on pwm_o.
// Wishbone registers: CTRL (en, inv), PERIOD (period-1), STATUS (underrun).
// Optional feature macro: WFG_DRIVE_PWM_UNDERRUN_CNT_EN adds a saturating
// 16-bit underrun counter in STATUS[31:16]; without it those bits read 0.
module wfg_drive_pwm #(
  parameter int BUSW = 32,
  parameter int CNTW = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  wfg_drive_pwm_if.slave  bus,
  output logic            pwm_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, RUN = 2'd2} state_t;

  // Everything the period engine carries from one cycle to the next.
  typedef struct packed {
    state_t          st;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] duty;
    logic [CNTW-1:0] per;
  } core_t;

  localparam logic [1:0] A_CTRL = 2'd0;
  localparam logic [1:0] A_PER  = 2'd1;
  localparam logic [1:0] A_STAT = 2'd2;

  // ---------------- Wishbone front end ----------------
  logic            ack_q;
  logic [BUSW-1:0] dat_q;
  logic            acc, wr;
  logic [1:0]      radr;
  logic [BUSW-1:0] wmask, wdat;
  logic [BUSW-1:0] rdata;

  logic            en, inv;
  logic [CNTW-1:0] period_r;
  logic            underrun;
  logic            evt;

  logic [BUSW-1:0] ctrl_rd, per_rd, stat_rd;
  logic [BUSW-1:0] ctrl_nxt, per_nxt;
  logic            stat_w1c, cnt_clr;

  // A new access is accepted only when ack is low, so each access is 2 cycles.
  assign acc  = bus.wbs_stb_i & bus.wbs_cyc_i & ~ack_q;
  assign wr   = acc & bus.wbs_we_i;
  assign radr = bus.wbs_adr_i[3:2];
  assign wdat = bus.wbs_dat_i;

  for (genvar g = 0; g < BUSW/8; g++) begin : g_mask
    assign wmask[g*8 +: 8] = {8{bus.wbs_sel_i[g]}};
  end

  assign ctrl_rd  = BUSW'({inv, en});
  assign per_rd   = BUSW'(period_r);
  assign ctrl_nxt = (ctrl_rd & ~wmask) | (wdat & wmask);
  assign per_nxt  = (per_rd  & ~wmask) | (wdat & wmask);

  assign stat_w1c = wr && (radr == A_STAT) && wmask[0]  && wdat[0];
  assign cnt_clr  = wr && (radr == A_STAT) && wmask[16] && wdat[16];

`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
  logic [15:0] ucnt;

  // Saturating underrun counter; an underrun in the clearing cycle counts as 1.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)         ucnt <= '0;
    else if (evt)         ucnt <= cnt_clr ? 16'd1 : ((ucnt == 16'hFFFF) ? ucnt : ucnt + 16'd1);
    else if (cnt_clr)     ucnt <= '0;
  end

  always_comb begin
    stat_rd        = '0;
    stat_rd[0]     = underrun;
    stat_rd[31:16] = ucnt;
  end
`else
  always_comb begin
    stat_rd    = '0;
    stat_rd[0] = underrun;
  end
`endif

  // Read mux; address 3 and anything unmapped reads zero.
  always_comb begin
    rdata = '0;
    unique case (radr)
      A_CTRL:  rdata = ctrl_rd;
      A_PER:   rdata = per_rd;
      A_STAT:  rdata = stat_rd;
      default: rdata = '0;
    endcase
  end

  // Ack one cycle after strobe; read data presented with ack, zero otherwise.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !bus.wbs_we_i) ? rdata : '0;
    end
  end

  // Register writes honour byte selects through the merged next values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      en       <= 1'b0;
      inv      <= 1'b0;
      period_r <= '0;
    end else if (wr) begin
      if (radr == A_CTRL) begin
        en  <= ctrl_nxt[0];
        inv <= ctrl_nxt[1];
      end
      if (radr == A_PER) period_r <= per_nxt[CNTW-1:0];
    end
  end

  // Sticky underrun flag; a new underrun beats a simultaneous clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) underrun <= 1'b0;
    else          underrun <= evt | (underrun & ~stat_w1c);
  end

  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

  // ---------------- Period engine ----------------
  core_t core_q, core_d;
  logic  tready;
  logic  pwm_d;

  // Engine state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) core_q <= '0;
    else          core_q <= core_d;
  end

  // Next state: fetch the first sample, then reload duty/period at each boundary.
  always_comb begin
    core_d = core_q;
    tready = 1'b0;
    evt    = 1'b0;
    if (!en) begin
      core_d.st  = IDLE;
      core_d.cnt = '0;
    end else begin
      unique case (core_q.st)
        IDLE: begin
          core_d.st  = FETCH;
          core_d.cnt = '0;
        end
        FETCH: begin
          tready = 1'b1;
          if (bus.wfg_axis_tvalid_i) begin
            core_d.duty = bus.wfg_axis_tdata_i[CNTW-1:0];
            core_d.per  = period_r;
            core_d.cnt  = '0;
            core_d.st   = RUN;
          end
        end
        RUN: begin
          if (core_q.cnt >= core_q.per) begin
            // Boundary cycle: only here is a new sample taken.
            tready     = 1'b1;
            core_d.cnt = '0;
            core_d.per = period_r;
            if (bus.wfg_axis_tvalid_i) core_d.duty = bus.wfg_axis_tdata_i[CNTW-1:0];
            else                       evt         = 1'b1;
          end else begin
            core_d.cnt = core_q.cnt + 1'b1;
          end
        end
        default: begin
          core_d.st  = IDLE;
          core_d.cnt = '0;
        end
      endcase
    end
  end

  // Output level follows the next count; idle and fetch sit at the inactive level.
  always_comb begin
    pwm_d = inv;
    if (core_d.st == RUN) pwm_d = (core_d.cnt < core_d.duty) ^ inv;
  end

  // Registered PWM pin.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) pwm_o <= 1'b0;
    else          pwm_o <= pwm_d;
  end

  assign bus.wfg_axis_tready_o = tready;

  logic unused_ok;
  assign unused_ok = ^{bus.wbs_adr_i[BUSW-1:4], bus.wbs_adr_i[1:0],
                       bus.wfg_axis_tdata_i[31:CNTW], ctrl_nxt[BUSW-1:2],
                       per_nxt[BUSW-1:CNTW], cnt_clr};

endmodule

// File: tb/tb_wfg_drive_pwm.sv
// Directed bench for wfg_drive_pwm: per-period high-time monitor, sample queue
// driving the stream, and Wishbone register accesses.
module tb_wfg_drive_pwm;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pwm;

  wfg_drive_pwm_if #(.BUSW(32)) ifc();

  wfg_drive_pwm #(.BUSW(32), .CNTW(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (ifc),
    .pwm_o    (pwm)
  );

  initial begin
    #5;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // ---- sample stream: tvalid whenever the queue holds a sample ----
  logic [31:0] q[$];
  logic [31:0] last_taken = '0;

  initial begin
    logic take;
    ifc.wfg_axis_tvalid_i = 1'b0;
    ifc.wfg_axis_tdata_i  = '0;
    forever begin
      @(negedge clk);
      take = ifc.wfg_axis_tvalid_i && ifc.wfg_axis_tready_o && !rst;
      @(posedge clk); #1;
      if (take) last_taken = q.pop_front();
      ifc.wfg_axis_tvalid_i = (q.size() > 0);
      ifc.wfg_axis_tdata_i  = (q.size() > 0) ? q[0] : 32'h0;
    end
  end

  // ---- monitor: one (high, length) entry per tready cycle ----
  int hi_acc = 0, len_acc = 0;
  int res_hi[$], res_len[$];

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        hi_acc  += int'(pwm);
        len_acc++;
        if (ifc.wfg_axis_tready_o) begin
          res_hi.push_back(hi_acc);
          res_len.push_back(len_acc);
          hi_acc  = 0;
          len_acc = 0;
        end
      end
    end
  end

  task automatic res_clr();
    res_hi.delete();
    res_len.delete();
  endtask

  task automatic wait_res(input int n);
    bit ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (res_hi.size() >= n) ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!ok) chk("wait_res", res_hi.size(), n);
  endtask

  // ---- Wishbone access; returns read data and ack latency in cycles ----
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    ifc.wbs_stb_i = 1'b1; ifc.wbs_cyc_i = 1'b1; ifc.wbs_we_i = we;
    ifc.wbs_adr_i = adr;  ifc.wbs_dat_i = dat;  ifc.wbs_sel_i = sel;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!ifc.wbs_ack_o && lat < 8);
    if (!ifc.wbs_ack_o) chk("wb_ack", ifc.wbs_ack_o, 1'b1);
    rd = ifc.wbs_dat_o;
    ifc.wbs_stb_i = 1'b0; ifc.wbs_cyc_i = 1'b0; ifc.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] d; int l;
    wb(1'b1, adr, dat, sel, d, l);
  endtask

  task automatic rd(input logic [31:0] adr, output logic [31:0] d);
    int l;
    wb(1'b0, adr, 32'h0, 4'hF, d, l);
  endtask

  localparam logic [31:0] R_CTRL = 32'h0, R_PER = 32'h4, R_STAT = 32'h8, R_3 = 32'hC;

`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
  localparam logic [31:0] T3_CNT = 32'h2;
`else
  localparam logic [31:0] T3_CNT = 32'h0;
`endif

  logic [31:0] d;
  int lat;

  initial begin
    ifc.wbs_stb_i = 0; ifc.wbs_cyc_i = 0; ifc.wbs_we_i = 0;
    ifc.wbs_sel_i = 0; ifc.wbs_dat_i = 0; ifc.wbs_adr_i = 0;

    // T1: reset before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("t1_pwm",    pwm, 0);
    chk("t1_tready", ifc.wfg_axis_tready_o, 0);
    chk("t1_ack",    ifc.wbs_ack_o, 0);
    chk("t1_dat",    ifc.wbs_dat_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd(R_CTRL, d); chk("t1_ctrl", d, 0);
    rd(R_PER,  d); chk("t1_per",  d, 0);
    rd(R_STAT, d); chk("t1_stat", d, 0);
    rd(R_3,    d); chk("t1_r3",   d, 0);

    // T2: 10-clock periods, duties 3,7,0,10 (10 saturates)
    wr(R_PER, 9);
    res_clr();
    q = '{32'd3, 32'd7, 32'd0, 32'd10};
    wr(R_CTRL, 1);
    wait_res(4);
    rd(R_STAT, d); chk("t2_stat", d, 0);
    wait_res(5);
    chk("t2_hi0", res_hi[1], 3);  chk("t2_len0", res_len[1], 10);
    chk("t2_hi1", res_hi[2], 7);  chk("t2_len1", res_len[2], 10);
    chk("t2_hi2", res_hi[3], 0);  chk("t2_len2", res_len[3], 10);
    chk("t2_hi3", res_hi[4], 10); chk("t2_len3", res_len[4], 10);
    wr(R_CTRL, 0);
    wr(R_STAT, 32'h0001_0001);
    rd(R_STAT, d); chk("t2_clr", d, 0);

    // T3: duty 2 in 5-clock periods, then two starved boundaries
    wr(R_PER, 4);
    res_clr();
    q = '{32'd2};
    wr(R_CTRL, 1);
    wait_res(3);
    wr(R_CTRL, 0);
    chk("t3_hi0", res_hi[1], 2); chk("t3_len0", res_len[1], 5);
    chk("t3_hi1", res_hi[2], 2); chk("t3_len1", res_len[2], 5);
    rd(R_STAT, d);
    chk("t3_flag", d[0], 1);
    chk("t3_cnt",  {16'h0, d[31:16]}, T3_CNT);
    wr(R_STAT, 32'h1);
    rd(R_STAT, d);
    chk("t3_w1c",  d[0], 0);
    chk("t3_keep", d, T3_CNT << 16);
    wr(R_STAT, 32'h0001_0000);
    rd(R_STAT, d); chk("t3_cclr", d, 0);

    // T4: PERIOD 9 -> 3 written mid-period
    wr(R_PER, 9);
    res_clr();
    q = '{32'd5, 32'd5, 32'd5};
    wr(R_CTRL, 1);
    wait_res(1);
    wr(R_PER, 3);
    wait_res(4);
    wr(R_CTRL, 0);
    chk("t4_len0", res_len[1], 10); chk("t4_hi0", res_hi[1], 5);
    chk("t4_len1", res_len[2], 4);  chk("t4_hi1", res_hi[2], 4);
    chk("t4_len2", res_len[3], 4);
    wr(R_STAT, 32'h0001_0001);

    // T5: inverted output, disable mid-period, pending sample survives
    wr(R_PER, 9);
    res_clr();
    q = '{32'd4, 32'd6};
    wr(R_CTRL, 3);
    wait_res(1);
    wr(R_CTRL, 2);
    @(posedge clk); @(negedge clk);
    chk("t5_pwm",    pwm, 1);
    chk("t5_tready", ifc.wfg_axis_tready_o, 0);
    repeat (4) @(negedge clk);
    chk("t5_pwm2",   pwm, 1);
    chk("t5_pend",   q.size(), 1);
    chk("t5_took",   last_taken, 4);
    res_clr();
    wr(R_CTRL, 3);
    wait_res(2);
    wr(R_CTRL, 0);
    chk("t5_next",   last_taken, 6);
    chk("t5_hi",     res_hi[1], 4);
    chk("t5_len",    res_len[1], 10);
    wr(R_STAT, 32'h0001_0001);

    // T6: Wishbone timing and byte selects
    wb(1'b1, R_PER, 32'h5A5A_ABCD, 4'hF, d, lat);
    chk("t6_lat", lat, 1);
    @(posedge clk); #1;
    chk("t6_ackdrop", ifc.wbs_ack_o, 0);
    wb(1'b0, R_PER, 32'h0, 4'hF, d, lat);
    chk("t6_rlat", lat, 1);
    chk("t6_per",  d, 32'h0000_ABCD);
    wr(R_PER, 32'h0000_1234, 4'b0001);
    rd(R_PER, d); chk("t6_sel", d, 32'h0000_AB34);
    wr(R_CTRL, 32'hFFFF_FFFF, 4'b0000);
    rd(R_CTRL, d); chk("t6_sel0", d, 0);
    wr(R_CTRL, 32'hFFFF_FFFE);
    rd(R_CTRL, d); chk("t6_ctrl", d, 2);
    wr(R_CTRL, 0);
    wr(R_3, 32'hFFFF_FFFF);
    rd(R_3, d); chk("t6_r3", d, 0);

    // T7: PERIOD=0, one-clock periods
    wr(R_PER, 0);
    res_clr();
    q = '{32'd1, 32'd0, 32'd1};
    wr(R_CTRL, 1);
    wait_res(4);
    wr(R_CTRL, 0);
    chk("t7_hi0", res_hi[1], 1); chk("t7_len0", res_len[1], 1);
    chk("t7_hi1", res_hi[2], 0); chk("t7_len1", res_len[2], 1);
    chk("t7_hi2", res_hi[3], 1); chk("t7_len2", res_len[3], 1);
    wr(R_STAT, 32'h0001_0001);

    // T8: reset mid-period
    wr(R_PER, 9);
    res_clr();
    q = '{32'd7};
    wr(R_CTRL, 1);
    wait_res(1);
    chk("t8_pre", pwm, 1);
    rst = 1'b1;
    #1;
    chk("t8_pwm",    pwm, 0);
    chk("t8_tready", ifc.wfg_axis_tready_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    rd(R_CTRL, d); chk("t8_ctrl", d, 0);
    rd(R_PER,  d); chk("t8_per",  d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
